// File: rtl/main_memory_responder_if.sv
// Request/response bundle between the cache controller (master) and main memory (slave).
// The bidirectional Data_Mem bus is carried as a split pair plus an output enable; the pad-level tristate sits outside.
// err_mem exists only when MEM_ERR_CHECK_EN is defined.
interface main_memory_responder_if;
  logic        read_Mem;     // read request, level, held until ready_mem seen
  logic        write_Mem;    // write request, level, held until ready_mem seen
  logic [31:0] Addr_Mem;     // byte address
  logic [31:0] Data_Mem_wr;  // Data_Mem as driven by the master (write data)
  logic [31:0] Data_Mem_rd;  // Data_Mem as driven by the responder (read data)
  logic        Data_Mem_oe;  // responder drives Data_Mem; low means responder side is Z
  logic        ready_mem;    // completion, held high until the request drops
`ifdef MEM_ERR_CHECK_EN
  logic        err_mem;      // flagged access, valid together with ready_mem
`endif

`ifdef MEM_ERR_CHECK_EN
  modport master (
    output read_Mem, write_Mem, Addr_Mem, Data_Mem_wr,
    input  Data_Mem_rd, Data_Mem_oe, ready_mem, err_mem
  );
  modport slave (
    input  read_Mem, write_Mem, Addr_Mem, Data_Mem_wr,
    output Data_Mem_rd, Data_Mem_oe, ready_mem, err_mem
  );
`else
  modport master (
    output read_Mem, write_Mem, Addr_Mem, Data_Mem_wr,
    input  Data_Mem_rd, Data_Mem_oe, ready_mem
  );
  modport slave (
    input  read_Mem, write_Mem, Addr_Mem, Data_Mem_wr,
    output Data_Mem_rd, Data_Mem_oe, ready_mem
  );
`endif
endinterface

// File: rtl/main_memory_responder.sv
// Main memory responder: one read/write at a time from the cache controller, word-addressed backing array.
// Latency: request accepted at edge N -> ready_mem high after edge N+LATENCY; 4-phase ready_mem completion.
// Backpressure: master holds the request level until ready_mem; ready_mem holds until both requests drop.
// Optional: MEM_ERR_CHECK_EN adds err_mem and rejects misaligned / out-of-range addresses.
module main_memory_responder #(
  parameter int LATENCY = 4,   // legal 1..255
  parameter int ADDR_W  = 12   // word index width; depth 2**ADDR_W words
) (
  input  logic                    clk,
  input  logic                    reset,
  main_memory_responder_if.slave  mem_bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter is loaded with LATENCY-1 on acceptance and the DONE transition happens on the
  // edge where it has reached zero, so acceptance + LATENCY edges gives ready_mem.
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_cnt;
  logic              r_is_wr;     // latched op: write wins when both requests are high
  logic              r_err;       // latched address-check result
  logic [ADDR_W-1:0] r_idx;       // latched word index
  logic [31:0]       r_wdat;      // latched write data
  logic [31:0]       r_rd;        // read result presented in DONE
  logic [31:0]       r_mem [2**ADDR_W];

  logic              w_req;
  logic              w_accept;
  logic              w_commit;
  logic              w_addr_bad;
  logic [ADDR_W-1:0] w_idx;

  assign w_req    = mem_bus.read_Mem | mem_bus.write_Mem;
  assign w_accept = (r_state == S_IDLE) && w_req;
  // Commit happens on the edge that moves WAIT -> DONE.
  assign w_commit = (r_state == S_WAIT) && (r_cnt == 8'd0);
  assign w_idx    = mem_bus.Addr_Mem[ADDR_W+1:2];

`ifdef MEM_ERR_CHECK_EN
  // Misaligned byte offset or any address bit beyond the array is rejected.
  assign w_addr_bad = (mem_bus.Addr_Mem[1:0] != 2'b00) ||
                      ((mem_bus.Addr_Mem >> (ADDR_W + 2)) != 32'd0);
`else
  // Unchecked build: low byte offset and upper address bits alias onto the array.
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{mem_bus.Addr_Mem[1:0], mem_bus.Addr_Mem >> (ADDR_W + 2)};
  assign w_addr_bad = 1'b0;
`endif

  // State register; asynchronous reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE -> WAIT -> DONE -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // Completion ends only once both request levels are sampled low.
        if (!w_req) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Request capture and latency countdown; bus changes after acceptance are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= 8'd0;
      r_is_wr <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_wdat  <= 32'd0;
    end else if (w_accept) begin
      r_cnt   <= CNT_LOAD;
      r_is_wr <= mem_bus.write_Mem;
      r_err   <= w_addr_bad;
      r_idx   <= w_idx;
      r_wdat  <= mem_bus.Data_Mem_wr;
    end else if ((r_state == S_WAIT) && (r_cnt != 8'd0)) begin
      r_cnt   <= r_cnt - 8'd1;
    end
  end

  // Backing array and read register; contents survive reset, a reset edge never commits.
  always_ff @(posedge clk) begin
    if (w_commit && !reset) begin
      if (r_is_wr) begin
        if (!r_err) begin
          r_mem[r_idx] <= r_wdat;
        end
      end else begin
        r_rd <= r_err ? ERR_DATA : r_mem[r_idx];
      end
    end
  end

  // Outputs: ready in DONE; read data driven only while the read request is still up.
  always_comb begin
    mem_bus.ready_mem   = (r_state == S_DONE);
    mem_bus.Data_Mem_oe = (r_state == S_DONE) && !r_is_wr && mem_bus.read_Mem;
    mem_bus.Data_Mem_rd = r_rd;
`ifdef MEM_ERR_CHECK_EN
    mem_bus.err_mem     = (r_state == S_DONE) && r_err;
`endif
  end

endmodule

// File: tb/tb_main_memory_responder.sv
// Bench for main_memory_responder: two instances (LATENCY 4 and 1) share clock and reset.
// Table-driven directed vectors, hand-written reset / protocol-violation sequences, then random traffic vs a reference model.
// Build with or without MEM_ERR_CHECK_EN; expectations follow the build.
module tb_main_memory_responder;

  localparam int AW = 12;
`ifdef MEM_ERR_CHECK_EN
  localparam bit ERRC = 1'b1;
`else
  localparam bit ERRC = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  main_memory_responder_if u_if0 ();
  main_memory_responder_if u_if1 ();

  logic        m_rd   [2];
  logic        m_wr   [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wdat [2];
  logic        s_rdy  [2];
  logic        s_oe   [2];
  logic        s_err  [2];
  logic [31:0] s_dat  [2];

  assign u_if0.read_Mem    = m_rd[0];
  assign u_if0.write_Mem   = m_wr[0];
  assign u_if0.Addr_Mem    = m_addr[0];
  assign u_if0.Data_Mem_wr = m_wdat[0];
  assign u_if1.read_Mem    = m_rd[1];
  assign u_if1.write_Mem   = m_wr[1];
  assign u_if1.Addr_Mem    = m_addr[1];
  assign u_if1.Data_Mem_wr = m_wdat[1];
  assign s_rdy[0] = u_if0.ready_mem;
  assign s_oe[0]  = u_if0.Data_Mem_oe;
  assign s_dat[0] = u_if0.Data_Mem_rd;
  assign s_rdy[1] = u_if1.ready_mem;
  assign s_oe[1]  = u_if1.Data_Mem_oe;
  assign s_dat[1] = u_if1.Data_Mem_rd;
`ifdef MEM_ERR_CHECK_EN
  assign s_err[0] = u_if0.err_mem;
  assign s_err[1] = u_if1.err_mem;
`else
  assign s_err[0] = 1'b0;
  assign s_err[1] = 1'b0;
`endif

  main_memory_responder #(.LATENCY(4), .ADDR_W(AW)) u_dut4 (.clk(clk), .reset(reset), .mem_bus(u_if0));
  main_memory_responder #(.LATENCY(1), .ADDR_W(AW)) u_dut1 (.clk(clk), .reset(reset), .mem_bus(u_if1));

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          lat;      // edges from acceptance edge to ready_mem high
    bit          oe;       // responder drove Data_Mem when ready_mem first seen
    logic [31:0] rdata;
    bit          drove;    // responder drove Data_Mem before completion
    bit          err;
    bit          hold;     // ready_mem still high one cycle later with request held
    bit          oe_drop;  // responder still driving right after request drop
    bit          fell;     // ready_mem low one edge after request drop
  } res_t;

  typedef struct {
    int          d;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdat;
    bit          scr;
    logic [31:0] rdata;
    bit          err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One master-side transaction on instance d, inputs changed on the falling edge.
  task automatic do_txn(input int d, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdat, input bit scramble, input bit drop_early,
                        output res_t r);
    int n;
    r.lat = -1; r.oe = 1'b0; r.rdata = 32'd0; r.drove = 1'b0; r.err = 1'b0;
    r.hold = 1'b1; r.oe_drop = 1'b0; r.fell = 1'b0;
    n = 0;
    @(negedge clk);
    m_rd[d] = rd; m_wr[d] = wr; m_addr[d] = addr; m_wdat[d] = wdat;
    while (n < 300) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (s_rdy[d]) break;
      if (s_oe[d]) r.drove = 1'b1;
      if (scramble) begin
        m_addr[d] = ~addr;
        m_wdat[d] = ~wdat;
      end
      if (drop_early) begin
        m_rd[d] = 1'b0;
        m_wr[d] = 1'b0;
      end
    end
    if (s_rdy[d]) begin
      r.lat   = n - 1;
      r.oe    = s_oe[d];
      r.rdata = s_dat[d];
      r.err   = s_err[d];
      if (!drop_early) begin
        @(posedge clk);
        @(negedge clk);
        r.hold = s_rdy[d] && (s_oe[d] == r.oe);
      end
    end
    m_rd[d] = 1'b0; m_wr[d] = 1'b0;
    #1;
    r.oe_drop = s_oe[d];
    @(posedge clk);
    @(negedge clk);
    r.fell = !s_rdy[d];
  endtask

  task automatic check_txn(input string tag, input res_t r, input int exp_lat, input bit exp_oe,
                           input bit chk_rd, input logic [31:0] exp_rd, input bit exp_err);
    check({tag, " latency"}, 32'(r.lat), 32'(exp_lat));
    check({tag, " drive_before_done"}, 32'(r.drove), 32'd0);
    check({tag, " drive_in_done"}, 32'(r.oe), 32'(exp_oe));
    if (exp_oe && chk_rd) check({tag, " rdata"}, r.rdata, exp_rd);
    check({tag, " err_mem"}, 32'(r.err), 32'(exp_err));
    check({tag, " ready_hold"}, 32'(r.hold), 32'd1);
    check({tag, " drive_after_drop"}, 32'(r.oe_drop), 32'd0);
    check({tag, " ready_fall"}, 32'(r.fell), 32'd1);
  endtask

  // Reference model: word store per instance keyed by instance and word index.
  logic [31:0] mdl [int];

  function automatic bit mdl_bad(input logic [31:0] a);
    return ERRC && ((a % 4) != 0 || (a / 4) >= (1 << AW));
  endfunction

  function automatic int mdl_key(input int d, input logic [31:0] a);
    return d * (1 << AW) + int'((a / 4) % (1 << AW));
  endfunction

  vec_t vecs [$];
  res_t res;

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_rd[i] = 1'b0; m_wr[i] = 1'b0; m_addr[i] = 32'd0; m_wdat[i] = 32'd0;
    end

    // Directed vectors: {dut, rd, wr, addr, wdata, scramble-in-wait, expected read data, expected err}
    vecs.push_back('{0, 1'b0, 1'b1, 32'h40,        32'h1234_5678, 1'b0, 32'h0,          1'b0});
    vecs.push_back('{0, 1'b1, 1'b0, 32'h40,        32'h0,         1'b0, 32'h1234_5678,  1'b0});
    vecs.push_back('{0, 1'b1, 1'b1, 32'h80,        32'hA5A5_A5A5, 1'b0, 32'h0,          1'b0});
    vecs.push_back('{0, 1'b1, 1'b0, 32'h80,        32'h0,         1'b0, 32'hA5A5_A5A5,  1'b0});
    vecs.push_back('{0, 1'b0, 1'b1, 32'h44,        32'h1111_2222, 1'b0, 32'h0,          1'b0});
    vecs.push_back('{0, 1'b0, 1'b1, 32'h84,        32'h55AA_55AA, 1'b0, 32'h0,          1'b0});
    vecs.push_back('{0, 1'b1, 1'b0, 32'h42,        32'h0,         1'b0,
                     ERRC ? 32'hDEAD_BEEF : 32'h1234_5678, ERRC});
    vecs.push_back('{0, 1'b1, 1'b0, 32'h40,        32'h0,         1'b0, 32'h1234_5678,  1'b0});
    vecs.push_back('{0, 1'b0, 1'b1, 32'h86,        32'h9999_9999, 1'b0, 32'h0,          ERRC});
    vecs.push_back('{0, 1'b1, 1'b0, 32'h84,        32'h0,         1'b0,
                     ERRC ? 32'h55AA_55AA : 32'h9999_9999, 1'b0});
    vecs.push_back('{0, 1'b1, 1'b0, 32'h0010_0080, 32'h0,         1'b0,
                     ERRC ? 32'hDEAD_BEEF : 32'hA5A5_A5A5, ERRC});
    vecs.push_back('{1, 1'b0, 1'b1, 32'h0,         32'hCAFE_F00D, 1'b0, 32'h0,          1'b0});
    vecs.push_back('{1, 1'b0, 1'b1, 32'h4,         32'h0BAD_F00D, 1'b0, 32'h0,          1'b0});
    vecs.push_back('{1, 1'b1, 1'b0, 32'h0,         32'h0,         1'b1, 32'hCAFE_F00D,  1'b0});
    vecs.push_back('{1, 1'b1, 1'b0, 32'h4,         32'h0,         1'b0, 32'h0BAD_F00D,  1'b0});
    vecs.push_back('{1, 1'b1, 1'b1, 32'h8,         32'h1357_9BDF, 1'b1, 32'h0,          1'b0});
    vecs.push_back('{1, 1'b1, 1'b0, 32'h8,         32'h0,         1'b0, 32'h1357_9BDF,  1'b0});
    vecs.push_back('{0, 1'b0, 1'b1, 32'h4C,        32'h2468_ACE0, 1'b1, 32'h0,          1'b0});
    vecs.push_back('{0, 1'b1, 1'b0, 32'h4C,        32'h0,         1'b0, 32'h2468_ACE0,  1'b0});

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset%0d ready_mem", i), 32'(s_rdy[i]), 32'd0);
      check($sformatf("reset%0d drive", i), 32'(s_oe[i]), 32'd0);
      check($sformatf("reset%0d err_mem", i), 32'(s_err[i]), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("post_reset ready_mem", 32'(s_rdy[0] | s_rdy[1]), 32'd0);

    // Table-driven directed vectors
    foreach (vecs[i]) begin
      do_txn(vecs[i].d, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdat, vecs[i].scr, 1'b0, res);
      check_txn($sformatf("v%0d", i), res, (vecs[i].d == 0) ? 4 : 1,
                vecs[i].rd && !vecs[i].wr, 1'b1, vecs[i].rdata, vecs[i].err);
    end

    // Reset during WAIT of a write: no commit, ready low at once, old data kept
    @(negedge clk);
    m_wr[0] = 1'b1; m_addr[0] = 32'h44; m_wdat[0] = 32'hFFFF_0000;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_wait ready_mem", 32'(s_rdy[0]), 32'd0);
    check("rst_wait drive", 32'(s_oe[0]), 32'd0);
    @(negedge clk);
    m_wr[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    do_txn(0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b0, res);
    check_txn("rst_wait_read", res, 4, 1'b1, 1'b1, 32'h1111_2222, 1'b0);

    // Reset during DONE of a read: ready and bus drive released immediately
    begin
      int n;
      n = 0;
      @(negedge clk);
      m_rd[0] = 1'b1; m_addr[0] = 32'h40;
      while (!s_rdy[0] && n < 50) begin
        @(posedge clk);
        @(negedge clk);
        n++;
      end
      check("rst_done pre drive", 32'(s_oe[0]), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("rst_done ready_mem", 32'(s_rdy[0]), 32'd0);
      check("rst_done drive", 32'(s_oe[0]), 32'd0);
      @(negedge clk);
      m_rd[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
    end

    // Request dropped during WAIT: still commits, one-cycle completion
    do_txn(0, 1'b0, 1'b1, 32'h48, 32'h7777_7777, 1'b0, 1'b1, res);
    check_txn("drop_wait", res, 4, 1'b0, 1'b0, 32'h0, 1'b0);
    do_txn(0, 1'b1, 1'b0, 32'h48, 32'h0, 1'b0, 1'b0, res);
    check_txn("drop_wait_read", res, 4, 1'b1, 1'b1, 32'h7777_7777, 1'b0);

    // Random traffic against the reference model, kept in a disjoint word range
    for (int t = 0; t < 150; t++) begin
      int d, op, key;
      bit rd, wr, bad, known, scr;
      logic [31:0] addr, wdat, exp_rd;
      d    = int'($urandom_range(0, 1));
      op   = int'($urandom_range(0, 2));
      rd   = (op != 1);
      wr   = (op != 0);
      addr = 32'h800 + 32'($urandom_range(0, 15)) * 4;
      if ($urandom_range(0, 3) == 0) addr = addr | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) addr = addr | (32'h1 << $urandom_range(14, 31));
      wdat = $urandom;
      scr  = ($urandom_range(0, 1) == 1);
      bad  = mdl_bad(addr);
      key  = mdl_key(d, addr);
      known  = 1'b1;
      exp_rd = 32'h0;
      if (wr) begin
        if (!bad) mdl[key] = wdat;
      end else if (bad) begin
        exp_rd = 32'hDEAD_BEEF;
      end else if (mdl.exists(key)) begin
        exp_rd = mdl[key];
      end else begin
        known = 1'b0;
      end
      do_txn(d, rd, wr, addr, wdat, scr, 1'b0, res);
      check_txn($sformatf("rnd%0d", t), res, (d == 0) ? 4 : 1, rd && !wr, known, exp_rd, bad);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
